// File: rtl/float_to_int.sv
// Decodes the 8-bit lab float (S, E[2:0], F[3:0]) into a 12-bit two's-complement integer
// by shifting the significand left one place per clock, then applying the sign.
module float_to_int (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               S,
    input  logic [2:0]         E,
    input  logic [3:0]         F,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [11:0] D
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] mag;
    logic [2:0]  cnt;
    logic        sgn;

    // Largest magnitude is 1920, so negation can never wrap into the sign bit.
    function automatic logic signed [11:0] apply_sign(input logic neg, input logic [11:0] m);
        logic [11:0] r;
        r = neg ? (~m + 12'd1) : m;
        return $signed(r);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 3'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // S/E/F are only looked at on the accept edge; D changes only when a new result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= 12'd0;
            cnt <= 3'd0;
            sgn <= 1'b0;
            D   <= 12'sd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag <= {8'b0, F};
                        cnt <= E;
                        sgn <= S;
                    end
                end
                SHIFT: begin
                    if (cnt != 3'd0) begin
                        mag <= mag << 1;
                        cnt <= cnt - 3'd1;
                    end else begin
                        D <= apply_sign(sgn, mag);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Directed-vector bench for float_to_int: latency, sign handling, backpressure,
// input isolation during a conversion, back-to-back throughput and async reset.
module tb_float_to_int;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               S;
    logic [2:0]         E;
    logic [3:0]         F;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] D;

    int tests;
    int fails;

    float_to_int dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one float for exactly one edge; entered and left at posedge+1.
    task automatic accept(input logic s, input logic [2:0] e, input logic [3:0] f);
        S        = s;
        E        = e;
        F        = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; saturates at 20.
    task automatic wait_valid(output int cycles);
        cycles = 1;
        @(posedge clk);
        #1;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        S = 1'b0; E = 3'd0; F = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 12'h000) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b D=%h, want 1 0 000", in_ready, out_valid, D);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 12'h000) begin
            fails++;
            $display("FAIL after_release: in_ready=%b out_valid=%b D=%h, want 1 0 000", in_ready, out_valid, D);
        end
        accept(1'b0, 3'd0, 4'd0);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_accept: in_ready=%b, want 0", in_ready);
        end
        wait_valid(lat);
        tests++;
        if (lat !== 1 || D !== 12'h000) begin
            fails++;
            $display("FAIL zero_conv: latency=%0d D=%h, want 1 000", lat, D);
        end
        consume();
    endtask

    task automatic test_extremes();
        int lat;
        accept(1'b0, 3'd7, 4'd15);
        wait_valid(lat);
        tests++;
        if (lat !== 8 || D !== 12'h780) begin
            fails++;
            $display("FAIL max_pos: latency=%0d D=%h, want 8 780", lat, D);
        end
        consume();
        accept(1'b1, 3'd7, 4'd15);
        wait_valid(lat);
        tests++;
        if (lat !== 8 || D !== 12'h880) begin
            fails++;
            $display("FAIL max_neg: latency=%0d D=%h, want 8 880", lat, D);
        end
        consume();
    endtask

    task automatic test_negative();
        int lat;
        accept(1'b1, 3'd3, 4'd9);
        wait_valid(lat);
        tests++;
        if (lat !== 4 || D !== 12'hFB8) begin
            fails++;
            $display("FAIL neg_72: latency=%0d D=%h, want 4 fb8", lat, D);
        end
        consume();
        accept(1'b1, 3'd5, 4'd0);
        wait_valid(lat);
        tests++;
        if (lat !== 6 || D !== 12'h000) begin
            fails++;
            $display("FAIL neg_zero: latency=%0d D=%h, want 6 000", lat, D);
        end
        consume();
        accept(1'b1, 3'd0, 4'd1);
        wait_valid(lat);
        tests++;
        if (lat !== 1 || D !== 12'hFFF) begin
            fails++;
            $display("FAIL neg_one: latency=%0d D=%h, want 1 fff", lat, D);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        accept(1'b0, 3'd2, 4'd5);
        wait_valid(lat);
        tests++;
        if (lat !== 3 || D !== 12'h014) begin
            fails++;
            $display("FAIL bp_result: latency=%0d D=%h, want 3 014", lat, D);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || D !== 12'h014) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL bp_hold: %0d bad cycles (last out_valid=%b in_ready=%b D=%h), want 0", bad, out_valid, in_ready, D);
        end
        consume();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        tests++;
        if (D !== 12'h014) begin
            fails++;
            $display("FAIL d_retained: D=%h, want 014", D);
        end
    endtask

    task automatic test_input_isolation();
        int lat;
        int extra;
        accept(1'b0, 3'd4, 4'd3);
        lat = 1;
        @(posedge clk);
        #1;
        while (!out_valid && lat < 20) begin
            in_valid = ~in_valid;
            S        = ~S;
            E        = E + 3'd3;
            F        = F + 4'd5;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        tests++;
        if (lat !== 5 || D !== 12'h030) begin
            fails++;
            $display("FAIL isolation_result: latency=%0d D=%h, want 5 030", lat, D);
        end
        consume();
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL no_second_accept: %0d busy cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int bad_d;
        S         = 1'b0;
        E         = 3'd1;
        F         = 4'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        pulses    = 0;
        bad_d     = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                pulses++;
                if (D !== 12'h006) bad_d++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (pulses !== 4) begin
            fails++;
            $display("FAIL b2b_count: %0d results in 16 cycles, want 4", pulses);
        end
        tests++;
        if (bad_d !== 0) begin
            fails++;
            $display("FAIL b2b_data: %0d results not 006, want 0", bad_d);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        int seen;
        accept(1'b0, 3'd6, 4'd7);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 12'h000) begin
            fails++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b D=%h, want 1 0 000", in_ready, out_valid, D);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL no_valid_after_reset: %0d valid cycles, want 0", seen);
        end
        accept(1'b0, 3'd1, 4'd8);
        wait_valid(lat);
        tests++;
        if (lat !== 2 || D !== 12'h010) begin
            fails++;
            $display("FAIL post_reset_conv: latency=%0d D=%h, want 2 010", lat, D);
        end
        consume();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_extremes();
        test_negative();
        test_backpressure();
        test_input_isolation();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
